// File: rtl/dmem_pkg.sv
// Shared definitions for the memory-stage data access unit: FSM states and funct3 size codes.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } stateT;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and lane-shifted store data from size and address offset.
// With DMEM_MISALIGN_TRAP_EN defined it also flags halfword/word accesses that are not naturally aligned.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic [31:0] writeData,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [3:0]  byteEn,
    output logic [31:0] laneData
);

    always_comb begin
        byteEn   = 4'b1111;
        laneData = writeData;
`ifdef DMEM_MISALIGN_TRAP_EN
        misalign = (addrLo != 2'b00);
`endif
        case (funct3)
            F3_B, F3_BU: begin
                byteEn   = 4'b0001 << addrLo;
                laneData = writeData << {addrLo, 3'b000};
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign = 1'b0;
`endif
            end
            F3_H, F3_HU: begin
                // addr[0] is dropped here; it only matters to the trap check
                byteEn   = 4'b0011 << {addrLo[1], 1'b0};
                laneData = writeData << {addrLo[1], 4'b0000};
`ifdef DMEM_MISALIGN_TRAP_EN
                misalign = addrLo[0];
`endif
            end
            default: begin
                byteEn   = 4'b1111;
                laneData = writeData;
            end
        endcase
    end

endmodule

// File: rtl/dmem_access_unit.sv
// Memory-stage data access unit: one req/ack bus transaction per load/store, with a bus watchdog.
// Optional DMEM_MISALIGN_TRAP_EN: misaligned h/w accesses skip the bus and complete with an error.
module dmem_access_unit
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int TIMER_W = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] MemDataM,
    output logic        DoneM,
    output logic        StallM,
    output logic        BusErrM,
`ifdef DMEM_MISALIGN_TRAP_EN
    output logic        MisalignM,
`endif
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_be,
    input  logic        bus_ack,
    input  logic [31:0] bus_rdata
);

    localparam logic [TIMER_W-1:0] TimeoutCnt = TIMER_W'(TIMEOUT);

    stateT              state;
    logic [TIMER_W-1:0] timer;
    logic [TIMER_W-1:0] waitCnt;
    logic               timeoutHit;
    logic [31:0]        rdataQ;
    logic               doneQ;
    logic               errQ;
    logic [3:0]         laneBe;
    logic [31:0]        laneData;
    logic               trapReq;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    logic misQ;

    assign trapReq   = misalign;
    assign MisalignM = misQ;
`else
    assign trapReq = 1'b0;
`endif

    dmem_lane_align uLaneAlign (
        .funct3    (Funct3M),
        .addrLo    (ALUResultM[1:0]),
        .writeData (WriteDataM),
`ifdef DMEM_MISALIGN_TRAP_EN
        .misalign  (misalign),
`endif
        .byteEn    (laneBe),
        .laneData  (laneData)
    );

    // timer counts finished wait cycles; the cycle that would reach TIMEOUT ends the access
    assign waitCnt    = timer + TIMER_W'(1);
    assign timeoutHit = (TIMEOUT != 0) && (waitCnt == TimeoutCnt);

    assign StallM   = MemReqM & (state != DONE);
    assign MemDataM = rdataQ;
    assign DoneM    = doneQ;
    assign BusErrM  = errQ;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            timer     <= '0;
            rdataQ    <= '0;
            doneQ     <= 1'b0;
            errQ      <= 1'b0;
            bus_req   <= 1'b0;
            bus_we    <= 1'b0;
            bus_addr  <= '0;
            bus_wdata <= '0;
            bus_be    <= '0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misQ      <= 1'b0;
`endif
        end else begin
            doneQ <= 1'b0;
            errQ  <= 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
            misQ  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (MemReqM && trapReq) begin
                        rdataQ <= '0;
                        doneQ  <= 1'b1;
                        errQ   <= 1'b1;
`ifdef DMEM_MISALIGN_TRAP_EN
                        misQ   <= 1'b1;
`endif
                        state  <= DONE;
                    end else if (MemReqM) begin
                        bus_req   <= 1'b1;
                        bus_we    <= MemWriteM;
                        bus_addr  <= {ALUResultM[31:2], 2'b00};
                        bus_wdata <= laneData;
                        bus_be    <= laneBe;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    // ack has priority over a coincident timeout
                    if (bus_ack) begin
                        if (!bus_we) rdataQ <= bus_rdata;
                        bus_req <= 1'b0;
                        doneQ   <= 1'b1;
                        state   <= DONE;
                    end else if (timeoutHit) begin
                        bus_req <= 1'b0;
                        rdataQ  <= '0;
                        doneQ   <= 1'b1;
                        errQ    <= 1'b1;
                        state   <= DONE;
                    end else begin
                        timer <= waitCnt;
                    end
                end
                DONE: begin
                    timer <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_access_unit.sv
// Randomised bench for dmem_access_unit: two instances (default watchdog and TIMEOUT=3)
// checked against a size/offset arithmetic reference model.
module tb_dmem_access_unit;

`ifdef DMEM_MISALIGN_TRAP_EN
    localparam bit TrapEn = 1'b1;
`else
    localparam bit TrapEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memWrite = 1'b0;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] aluResult = '0;
    logic [31:0] writeData = '0;
    logic [31:0] busRdata = '0;

    logic        reqA = 1'b0, ackA = 1'b0;
    logic [31:0] memDataA, busAddrA, busWdataA;
    logic        doneA, stallA, errA, busReqA, busWeA;
    logic [3:0]  busBeA;

    logic        reqB = 1'b0, ackB = 1'b0;
    logic [31:0] memDataB, busAddrB, busWdataB;
    logic        doneB, stallB, errB, busReqB, busWeB;
    logic [3:0]  busBeB;

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misA, misB;
`endif

    int nTests = 0;
    int nFail  = 0;
    logic [31:0] lastRd = '0;

    always #5 clk = ~clk;

    dmem_access_unit dutA (
        .clk(clk), .reset(reset), .MemReqM(reqA), .MemWriteM(memWrite), .Funct3M(funct3),
        .ALUResultM(aluResult), .WriteDataM(writeData), .MemDataM(memDataA), .DoneM(doneA),
        .StallM(stallA), .BusErrM(errA),
`ifdef DMEM_MISALIGN_TRAP_EN
        .MisalignM(misA),
`endif
        .bus_req(busReqA), .bus_we(busWeA), .bus_addr(busAddrA), .bus_wdata(busWdataA),
        .bus_be(busBeA), .bus_ack(ackA), .bus_rdata(busRdata)
    );

    dmem_access_unit #(.TIMEOUT(3)) dutB (
        .clk(clk), .reset(reset), .MemReqM(reqB), .MemWriteM(memWrite), .Funct3M(funct3),
        .ALUResultM(aluResult), .WriteDataM(writeData), .MemDataM(memDataB), .DoneM(doneB),
        .StallM(stallB), .BusErrM(errB),
`ifdef DMEM_MISALIGN_TRAP_EN
        .MisalignM(misB),
`endif
        .bus_req(busReqB), .bus_we(busWeB), .bus_addr(busAddrB), .bus_wdata(busWdataB),
        .bus_be(busBeB), .bus_ack(ackB), .bus_rdata(busRdata)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference model: access size in bytes, lane offset rounded down to the size
    function automatic int sizeOf(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int laneOff(input logic [2:0] f3, input logic [31:0] addr);
        int n = sizeOf(f3);
        int off = int'(addr % 4);
        return off - (off % n);
    endfunction

    function automatic logic [31:0] refBe(input logic [2:0] f3, input logic [31:0] addr);
        int n = sizeOf(f3);
        return ((32'd1 << n) - 32'd1) << laneOff(f3, addr);
    endfunction

    function automatic logic [31:0] refWdata(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] wd);
        return wd << (8 * laneOff(f3, addr));
    endfunction

    // Full access on dutA; caller and task both sit just after a rising edge
    task automatic accessA(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input logic [31:0] rdata, input int waits);
        int  n = sizeOf(f3);
        bit  mis = TrapEn && (n > 1) && ((addr % n) != 0);
        int  expCyc = mis ? 2 : waits + 3;
        int  doneCyc = 0;
        int  stallCnt = 0;
        logic [31:0] expData;
        reqA = 1'b1; memWrite = we; funct3 = f3; aluResult = addr; writeData = wd;
        for (int cyc = 1; cyc <= waits + 12; cyc++) begin
            ackA = !mis && (cyc == waits + 2);
            busRdata = ackA ? rdata : $urandom;
            @(negedge clk);
            if (doneA) begin
                doneCyc = cyc;
                break;
            end
            if (stallA) stallCnt++;
            if (mis) begin
                chk("misNoReq", 32'(busReqA), 32'd0);
            end else if (cyc >= 2) begin
                chk("busReq", 32'(busReqA), 32'd1);
                chk("busAddr", busAddrA, addr & 32'hFFFF_FFFC);
                chk("busBe", 32'(busBeA), refBe(f3, addr));
                chk("busWe", 32'(busWeA), 32'(we));
                if (we) chk("busWdata", busWdataA, refWdata(f3, addr, wd));
            end
            @(posedge clk); #1;
        end
        expData = (mis || !we) ? (mis ? 32'd0 : rdata) : lastRd;
        chk("doneCycle", 32'(doneCyc), 32'(expCyc));
        chk("stallCycles", 32'(stallCnt), 32'(expCyc - 1));
        chk("stallInDone", 32'(stallA), 32'd0);
        chk("busErr", 32'(errA), 32'(mis));
        chk("memData", memDataA, expData);
        chk("reqDropped", 32'(busReqA), 32'd0);
`ifdef DMEM_MISALIGN_TRAP_EN
        chk("misalignM", 32'(misA), 32'(mis));
`endif
        lastRd = expData;
        @(posedge clk); #1;
        reqA = 1'b0; ackA = 1'b0;
    endtask

    // Word load on dutB (TIMEOUT=3); ackCyc 0 means the bus never answers
    task automatic accessB(input int ackCyc);
        logic [31:0] rdata = $urandom;
        bit   acked = (ackCyc >= 2) && (ackCyc <= 4);
        int   expCyc = acked ? ackCyc + 1 : 5;
        int   doneCyc = 0;
        int   reqCnt = 0;
        reqB = 1'b1; memWrite = 1'b0; funct3 = 3'b010; aluResult = {$urandom} & 32'hFFFF_FFFC;
        for (int cyc = 1; cyc <= 12; cyc++) begin
            ackB = (cyc == ackCyc);
            busRdata = ackB ? rdata : $urandom;
            @(negedge clk);
            if (doneB) begin
                doneCyc = cyc;
                break;
            end
            if (busReqB) reqCnt++;
            @(posedge clk); #1;
        end
        chk("toDoneCycle", 32'(doneCyc), 32'(expCyc));
        chk("toReqCycles", 32'(reqCnt), 32'(expCyc - 2));
        chk("toBusErr", 32'(errB), 32'(!acked));
        chk("toMemData", memDataB, acked ? rdata : 32'd0);
        chk("toReqLow", 32'(busReqB), 32'd0);
        @(posedge clk); #1;
        reqB = 1'b0; ackB = 1'b0;
    endtask

    initial begin
        logic [2:0] f3Tab [8] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rstBusReq", 32'(busReqA), 32'd0);
        chk("rstBusWe", 32'(busWeA), 32'd0);
        chk("rstBusAddr", busAddrA, 32'd0);
        chk("rstBusWdata", busWdataA, 32'd0);
        chk("rstBusBe", 32'(busBeA), 32'd0);
        chk("rstMemData", memDataA, 32'd0);
        chk("rstDone", 32'(doneA), 32'd0);
        chk("rstBusErr", 32'(errA), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;

        // Reset pulled mid-BUSY
        reqA = 1'b1; memWrite = 1'b0; funct3 = 3'b010; aluResult = 32'h40;
        @(posedge clk); #1;
        @(negedge clk);
        chk("midBusyReq", 32'(busReqA), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("asyncReqDrop", 32'(busReqA), 32'd0);
        chk("stallEqReq", 32'(stallA), 32'(reqA));
        reqA = 1'b0;
        #1;
        chk("stallEqReq0", 32'(stallA), 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        chk("postRstReq", 32'(busReqA), 32'd0);
        chk("postRstDone", 32'(doneA), 32'd0);
        chk("postRstData", memDataA, 32'd0);
        lastRd = '0;
        @(posedge clk); #1;

        // Directed accesses
        accessA(1'b1, 3'b010, 32'h104, 32'hDEAD_BEEF, 32'h0, 0);
        accessA(1'b1, 3'b000, 32'h203, 32'h0000_00A5, 32'h0, 2);
        accessA(1'b0, 3'b101, 32'h102, 32'h0, 32'h1234_ABCD, 4);
        accessA(1'b0, 3'b000, 32'h301, 32'h0, 32'hCAFE_F00D, 1);
        accessA(1'b1, 3'b001, 32'h3FE, 32'h0000_5A5A, 32'h0, 0);
        accessA(1'b0, 3'b111, 32'h503, 32'h0, 32'h0BAD_F00D, 0);
        accessA(1'b0, 3'b010, 32'h102, 32'h0, 32'h1111_2222, 0);

        // Watchdog on the TIMEOUT=3 instance
        accessB(0);
        accessB(4);
        accessB(3);
        accessB(2);

        // Randomised traffic
        for (int i = 0; i < 40; i++) begin
            accessA(1'($urandom), f3Tab[$urandom_range(0, 7)], $urandom, $urandom, $urandom,
                    int'($urandom_range(0, 5)));
        end

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
